// File: rtl/alct_pkg.sv
// Shared definitions for the ALCT receive link checker.
package alct_pkg;

  localparam int unsigned WIDTH_DEF    = 28;
  localparam int unsigned LOCK_CNT_DEF = 8;
  localparam int unsigned LOST_CNT_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } link_state_t;

endpackage

// File: rtl/alct_rx_link_check_if.sv
// Receive word pair, control inputs and link status outputs of the checker.
interface alct_rx_link_check_if #(
  parameter int unsigned WIDTH = alct_pkg::WIDTH_DEF,
  parameter int unsigned CNT_W = alct_pkg::CNT_W_DEF
) ();

  logic             enable;
  logic             clr_cnt;
  logic [WIDTH-1:0] rx1st;
  logic [WIDTH-1:0] rx2nd;
  logic             locked;
  logic             err_pulse;
  logic             lost_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic [WIDTH-1:0] bad_bits;

  modport master (
    output enable, clr_cnt, rx1st, rx2nd,
    input  locked, err_pulse, lost_pulse, err_cnt, frame_cnt, bad_bits
  );

  modport slave (
    input  enable, clr_cnt, rx1st, rx2nd,
    output locked, err_pulse, lost_pulse, err_cnt, frame_cnt, bad_bits
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter
  import alct_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register with saturation at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/alct_rx_link_check.sv
// ALCT receive link checker: locks onto the incrementing/complement test
// pattern and counts bad frames, locked frames and failing bit positions.
// LOCK_CNT is expected to be at least 2 (the SEEK frame counts as the first).
module alct_rx_link_check
  import alct_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
  parameter int unsigned LOST_CNT = LOST_CNT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input logic               clock,
  input logic               reset_n,
  alct_rx_link_check_if.slave link
);

  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(LOST_CNT + 1);

  link_state_t       state;
  logic [WIDTH-1:0]  exp_word;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss_run;

  logic [WIDTH-1:0]  mask_c;
  logic              pair_ok_c;
  logic              good_c;
  logic              lock_frame_c;
  logic              err_inc_c;

  // Frame classification against the expected word
  always_comb begin
    mask_c       = (link.rx1st ^ exp_word) | (link.rx2nd ^ ~exp_word);
    pair_ok_c    = (link.rx2nd == ~link.rx1st);
    good_c       = (mask_c == '0);
    lock_frame_c = link.enable && (state == ST_LOCKED);
    err_inc_c    = lock_frame_c && !good_c;
  end

  // Link state machine with registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      exp_word        <= '0;
      run             <= '0;
      miss_run        <= '0;
      link.locked     <= 1'b0;
      link.err_pulse  <= 1'b0;
      link.lost_pulse <= 1'b0;
      link.bad_bits   <= '0;
    end else begin
      link.err_pulse  <= 1'b0;
      link.lost_pulse <= 1'b0;

      if (link.clr_cnt) begin
        link.bad_bits <= '0;
      end else if (lock_frame_c) begin
        link.bad_bits <= link.bad_bits | mask_c;
      end

      if (!link.enable) begin
        state       <= ST_IDLE;
        run         <= '0;
        miss_run    <= '0;
        link.locked <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_SEEK;
          end
          ST_SEEK: begin
            if (pair_ok_c) begin
              state    <= ST_ACQUIRE;
              exp_word <= link.rx1st + WIDTH'(1);
              run      <= RUN_W'(1);
            end
          end
          ST_ACQUIRE: begin
            if (good_c) begin
              exp_word <= exp_word + WIDTH'(1);
              run      <= run + RUN_W'(1);
              if ((run + RUN_W'(1)) == RUN_W'(LOCK_CNT)) begin
                state       <= ST_LOCKED;
                miss_run    <= '0;
                link.locked <= 1'b1;
              end
            end else begin
              state <= ST_SEEK;
            end
          end
          ST_LOCKED: begin
            exp_word <= exp_word + WIDTH'(1);
            if (good_c) begin
              miss_run <= '0;
            end else begin
              link.err_pulse <= 1'b1;
              if ((miss_run + MISS_W'(1)) == MISS_W'(LOST_CNT)) begin
                state           <= ST_SEEK;
                miss_run        <= '0;
                link.locked     <= 1'b0;
                link.lost_pulse <= 1'b1;
              end else begin
                miss_run <= miss_run + MISS_W'(1);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Bad-frame counter
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clock),
    .rst_n (reset_n),
    .clr   (link.clr_cnt),
    .inc   (err_inc_c),
    .cnt   (link.err_cnt)
  );

  // Locked-frame counter
  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk   (clock),
    .rst_n (reset_n),
    .clr   (link.clr_cnt),
    .inc   (lock_frame_c),
    .cnt   (link.frame_cnt)
  );

endmodule

// File: doc/alct_rx_link_check.md
ALCT_RX_LINK_CHECK -- requirements
Module: alct_rx_link_check

Interface
REQ-001 Parameter WIDTH, default 28: bit width of each de-multiplexed ALCT word.
REQ-002 Parameter LOCK_CNT, default 8: consecutive good frames required to declare lock.
REQ-003 Parameter LOST_CNT, default 4: consecutive bad frames while locked that force re-seek.
REQ-004 Parameter CNT_W, default 16: width of the error and frame counters.
REQ-005 Port clock, input, 1: 40MHz TMB main clock; sole clock; all logic on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port enable, input, 1: link check enable, from the VME config register.
REQ-008 Port clr_cnt, input, 1: synchronous clear of err_cnt, frame_cnt and sticky flags.
REQ-009 Port rx1st, input, WIDTH: 1st-in-time word, from the ALCT DDR demux stage.
REQ-010 Port rx2nd, input, WIDTH: 2nd-in-time word, from the same demux stage.
REQ-011 Port locked, output, 1: link locked to the ALCT test pattern.
REQ-012 Port err_pulse, output, 1: one-cycle pulse per bad frame while LOCKED.
REQ-013 Port lost_pulse, output, 1: one-cycle pulse on the LOCKED-to-SEEK transition.
REQ-014 Port err_cnt, output, CNT_W: saturating bad-frame count.
REQ-015 Port frame_cnt, output, CNT_W: saturating count of frames checked while LOCKED.
REQ-016 Port bad_bits, output, WIDTH: sticky OR of the per-bit mismatch mask while LOCKED.

Function
REQ-017 Test pattern is defined as: rx2nd == ~rx1st, and rx1st increments by 1 per clock, modulo 2^WIDTH.
REQ-018 A frame SHALL be "pair-ok" when rx2nd == ~rx1st.
REQ-019 A frame SHALL be "good" when it is pair-ok and rx1st == exp, where exp is the expected-word register.
REQ-020 States are IDLE, SEEK, ACQUIRE and LOCKED; enable=0 SHALL force IDLE from any state on the next clock.
REQ-021 IDLE -> SEEK when enable=1.
REQ-022 SEEK: on a pair-ok frame, go to ACQUIRE, load exp <= rx1st+1 and set run <= 1; otherwise remain in SEEK.
REQ-023 ACQUIRE: on a good frame, run increments and exp increments; when run reaches LOCK_CNT, go to LOCKED; on any non-good frame, return to SEEK.
REQ-024 LOCKED:
- exp SHALL increment every clock regardless of match.
- A good frame clears miss_run.
- A bad frame increments err_cnt, increments miss_run and asserts err_pulse.
- When miss_run reaches LOST_CNT, go to SEEK and assert lost_pulse.
REQ-025 Mismatch mask = (rx1st ^ exp) | (rx2nd ^ ~exp); bad_bits SHALL OR in this mask on each LOCKED frame.
REQ-026 frame_cnt SHALL increment on every LOCKED clock.
REQ-027 err_cnt and frame_cnt SHALL saturate at all-ones and never wrap.
REQ-028 exp SHALL wrap from all-ones to zero without being flagged as an error.
REQ-029 All outputs SHALL be registered, with latency of 1 clock from the sampled frame.
REQ-030 locked SHALL be high exactly while the state is LOCKED.
REQ-031 clr_cnt SHALL take priority over a simultaneous increment (count result 0) and SHALL NOT change state.
REQ-032 Deasserting enable while LOCKED SHALL drop locked next clock, with no lost_pulse; the counters hold their values.

Reset
REQ-033 reset_n low SHALL asynchronously set the state to IDLE.
REQ-034 reset_n low SHALL clear exp, run, miss_run, err_cnt, frame_cnt, bad_bits, locked, err_pulse and lost_pulse to 0.
REQ-035 Reset release SHALL take effect at the next rising clock edge; reset mid-lock SHALL require full reacquisition.

Structure
REQ-036 The state encoding and the LOCK_CNT, LOST_CNT and CNT_W defaults SHALL live in the shared package alct_pkg.
REQ-037 A single sub-module, sat_counter (saturating counter with synchronous clear), SHALL be instantiated for err_cnt and frame_cnt.

Verification
REQ-038 Lock acquisition: enable=1; pattern starting at 0x0000010 -> locked rises 1 clock after the 8th good frame; err_cnt=0.
REQ-039 Single error: while locked, flip rx1st bit 3 for one frame -> err_pulse once; err_cnt=1; bad_bits=0x0000008; locked stays 1.
REQ-040 Link loss: while locked, 4 consecutive bad frames -> lost_pulse once; locked=0; state SEEK; err_cnt=4.
REQ-041 Wrap-around: lock, then stream through 0xFFFFFFF -> 0x0000000 -> err_cnt stays 0 and locked stays 1.
REQ-042 Saturation and clear:
- Force err_cnt to 0xFFFF; inject a bad frame -> err_cnt holds 0xFFFF.
- Assert clr_cnt together with a bad frame -> err_cnt=0.
REQ-043 Reset mid-lock: assert reset_n=0 asynchronously -> all outputs read 0 immediately; after release, locked=0 until 8 new good frames.
